// File: rtl/mmio_fifo_csr.sv
// mmio_fifo_csr: bank of MMIO-mapped FIFO channels. Each channel is a circular
// buffer that host writes push into and host reads pop or peek from, with a
// STATUS word, sticky overflow/underflow flags and a flush/clear CTRL register.
// Each read request gets exactly one registered response one cycle later.
module mmio_fifo_csr #(
   parameter int          WIDTH     = 64,
   parameter int          DEPTH     = 16,
   parameter int          NUM_CH    = 2,
   parameter logic [15:0] BASE_ADDR = 16'h0020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [15:0] wr_addr,
   input  logic [63:0] wr_data,
   input  logic        rd_valid,
   input  logic [15:0] rd_addr,
   input  logic [8:0]  rd_tid,
   output logic        resp_valid,
   output logic [8:0]  resp_tid,
   output logic [63:0] resp_data
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [WIDTH-1:0]  r_mem    [NUM_CH][DEPTH];
   logic [AW-1:0]     r_rd_ptr [NUM_CH];
   logic [AW-1:0]     r_wr_ptr [NUM_CH];
   logic [CW-1:0]     r_count  [NUM_CH];
   logic [NUM_CH-1:0] r_ovf;
   logic [NUM_CH-1:0] r_udf;

   logic [15:0]       w_rd_rel, w_wr_rel;
   logic              w_rd_hit, w_wr_hit;
   logic [CHW-1:0]    w_rd_ch, w_wr_ch;
   logic [2:0]        w_rd_off, w_wr_off;
   logic [CW-1:0]     w_rd_cnt, w_wr_cnt;
   logic [WIDTH-1:0]  w_rd_head;
   logic [63:0]       w_rd_data;
   logic              w_pop, w_udf_set;
   logic              w_push, w_ovf_set, w_flush, w_clr;
   logic [NUM_CH-1:0] w_pop_v, w_udf_v, w_push_v, w_ovf_v, w_flush_v, w_clr_v;
   logic              w_unused;

   // Address decode: channel = (addr - base) / 8, register = low three bits.
   assign w_rd_rel  = rd_addr - BASE_ADDR;
   assign w_wr_rel  = wr_addr - BASE_ADDR;
   assign w_rd_hit  = (rd_addr >= BASE_ADDR) && (w_rd_rel[15:3] < 13'(NUM_CH));
   assign w_wr_hit  = (wr_addr >= BASE_ADDR) && (w_wr_rel[15:3] < 13'(NUM_CH));
   assign w_rd_ch   = w_rd_rel[3 +: CHW];
   assign w_wr_ch   = w_wr_rel[3 +: CHW];
   assign w_rd_off  = w_rd_rel[2:0];
   assign w_wr_off  = w_wr_rel[2:0];
   assign w_rd_cnt  = r_count[w_rd_ch];
   assign w_wr_cnt  = r_count[w_wr_ch];
   assign w_rd_head = r_mem[w_rd_ch][r_rd_ptr[w_rd_ch]];
   assign w_unused  = ^wr_data;

   // Read side: response data and pop/underflow events, all from pre-write state.
   always_comb begin
      w_rd_data = '0;
      w_pop     = 1'b0;
      w_udf_set = 1'b0;
      if (rd_valid && w_rd_hit) begin
         case (w_rd_off)
            3'd0: begin
               if (w_rd_cnt != '0) begin
                  w_rd_data = 64'(w_rd_head);
                  w_pop     = 1'b1;
               end else begin
                  w_udf_set = 1'b1;
               end
            end
            3'd2: begin
               if (w_rd_cnt != '0) w_rd_data = 64'(w_rd_head);
            end
            3'd4: begin
               w_rd_data = {44'b0, r_udf[w_rd_ch], r_ovf[w_rd_ch],
                            (w_rd_cnt == CW'(DEPTH)), (w_rd_cnt == '0),
                            16'(w_rd_cnt)};
            end
            default: ;
         endcase
      end
   end

   // Write side: a push into a full channel only succeeds if that channel pops now.
   always_comb begin
      w_push    = 1'b0;
      w_ovf_set = 1'b0;
      w_flush   = 1'b0;
      w_clr     = 1'b0;
      if (wr_valid && w_wr_hit) begin
         case (w_wr_off)
            3'd0: begin
               if ((w_wr_cnt != CW'(DEPTH)) || (w_pop && (w_rd_ch == w_wr_ch)))
                  w_push = 1'b1;
               else
                  w_ovf_set = 1'b1;
            end
            3'd6: begin
               w_flush = wr_data[0];
               w_clr   = wr_data[1];
            end
            default: ;
         endcase
      end
   end

   // Fan the decoded events out to per-channel enables.
   always_comb begin
      w_pop_v   = '0;
      w_udf_v   = '0;
      w_push_v  = '0;
      w_ovf_v   = '0;
      w_flush_v = '0;
      w_clr_v   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_pop_v[c]   = w_pop     && (w_rd_ch == CHW'(c));
         w_udf_v[c]   = w_udf_set && (w_rd_ch == CHW'(c));
         w_push_v[c]  = w_push    && (w_wr_ch == CHW'(c));
         w_ovf_v[c]   = w_ovf_set && (w_wr_ch == CHW'(c));
         w_flush_v[c] = w_flush   && (w_wr_ch == CHW'(c));
         w_clr_v[c]   = w_clr     && (w_wr_ch == CHW'(c));
      end
   end

   // Per-channel pointers, occupancy and sticky flags; flush overrides a same-cycle pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_rd_ptr[c] <= '0;
            r_wr_ptr[c] <= '0;
            r_count[c]  <= '0;
         end
         r_ovf <= '0;
         r_udf <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_flush_v[c]) begin
               r_rd_ptr[c] <= r_wr_ptr[c];
               r_count[c]  <= '0;
            end else begin
               if (w_push_v[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
               if (w_pop_v[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
               if (w_push_v[c] && !w_pop_v[c])
                  r_count[c] <= r_count[c] + 1'b1;
               else if (!w_push_v[c] && w_pop_v[c])
                  r_count[c] <= r_count[c] - 1'b1;
            end
         end
         r_ovf <= (r_ovf & ~w_clr_v) | w_ovf_v;
         r_udf <= (r_udf & ~w_clr_v) | w_udf_v;
      end
   end

   // Data storage; no reset needed since the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wr_ch][r_wr_ptr[w_wr_ch]] <= wr_data[WIDTH-1:0];
   end

   // Registered read response, one per read request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_tid   <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= rd_valid;
         resp_tid   <= rd_valid ? rd_tid : '0;
         resp_data  <= w_rd_data;
      end
   end

endmodule
